cam_ctrl: RTL and testbench

Request-side controller for the 16-entry, 8-bit content-addressable memory `cam`. It accepts insert and delete requests through a valid/ready handshake and uses the CAM search port to detect duplicates and locate keys. It keeps the occupancy bitmap, allocates the lowest free slot, and drives the CAM write port. It sits directly upstream of `cam`, and its `cam_*` outputs connect straight to the CAM inputs.

---
 rtl/cam_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cam_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_ctrl.sv
// Insert/delete controller for a 16x8 CAM: dedups via search port, allocates lowest free slot.
// Fixed 3-cycle request-to-response latency, one request per 4 cycles; req_ready only in IDLE.
module cam_ctrl #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int EMPTY_KEY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_key,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] cam_srch_data,
    input  logic              cam_found,
    input  logic [ADDR_W-1:0] cam_srch_addr,
    output logic              cam_wr_en,
    output logic [7:0]        cam_wr_addr,
    output logic [DATA_W-1:0] cam_wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_DUP  = 2'b01;
    localparam logic [1:0] ST_FULL = 2'b10;
    localparam logic [1:0] ST_MISS = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_WRITE, S_RESP} state_t;

    state_t              state_q;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DATA_W-1:0]   key_q;
    logic                op_q;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, empty_q;
    logic [1:0]          status_q;
    logic [ADDR_W-1:0]   slot_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                rsp_valid_q;

    logic [ADDR_W-1:0]   free_slot;
    logic [1:0]          res_status;
    logic [ADDR_W-1:0]   res_slot;
    logic                res_wr;

    // Scan downward so the lowest free index wins.
    always_comb begin
        free_slot = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_slot = ADDR_W'(i);
        end
    end

    always_comb begin
        res_status = ST_MISS;
        res_slot   = '0;
        res_wr     = 1'b0;
        if (key_q == DATA_W'(EMPTY_KEY)) begin
            res_status = ST_MISS;
        end else if (!op_q) begin
            if (cam_found) begin
                res_status = ST_DUP;
                res_slot   = cam_srch_addr;
            end else if (full_q) begin
                res_status = ST_FULL;
            end else begin
                res_status = ST_OK;
                res_slot   = free_slot;
                res_wr     = 1'b1;
            end
        end else if (cam_found) begin
            res_status = ST_OK;
            res_slot   = cam_srch_addr;
            res_wr     = 1'b1;
        end
    end

    // Occupancy commits on the edge that ends WRITE, together with the CAM write.
    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        if (state_q == S_WRITE && wr_en_q) begin
            if (!op_q) begin
                valid_d[wr_addr_q] = 1'b1;
                count_d            = count_q + 1'b1;
            end else begin
                valid_d[wr_addr_q] = 1'b0;
                count_d            = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            key_q       <= '0;
            op_q        <= 1'b0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            status_q    <= ST_OK;
            slot_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            count_q     <= count_d;
            full_q      <= (count_d == (ADDR_W + 1)'(DEPTH));
            empty_q     <= (count_d == '0);
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        key_q   <= req_key;
                        op_q    <= req_op;
                        state_q <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    status_q <= res_status;
                    slot_q   <= res_slot;
                    wr_en_q  <= res_wr;
                    if (res_wr) begin
                        wr_addr_q <= res_slot;
                        wr_data_q <= op_q ? DATA_W'(EMPTY_KEY) : key_q;
                    end
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Reset masks the pulses combinationally so nothing escapes during the reset cycle.
    assign req_ready     = (state_q == S_IDLE) && !rst;
    assign rsp_valid     = rsp_valid_q && !rst;
    assign cam_wr_en     = wr_en_q && !rst;
    assign rsp_status    = status_q;
    assign rsp_addr      = slot_q;
    assign cam_srch_data = key_q;
    assign cam_wr_addr   = {{(8 - ADDR_W){1'b0}}, wr_addr_q};
    assign cam_wr_data   = wr_data_q;
    assign count         = count_q;
    assign full          = full_q;
    assign empty         = empty_q;
endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: behavioural CAM plus a slot-table reference model; randomized and directed scenarios.
module tb_cam_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_op;
    logic [7:0] req_key;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic [3:0] rsp_addr;
    logic [7:0] cam_srch_data;
    logic       cam_found;
    logic [3:0] cam_srch_addr;
    logic       cam_wr_en;
    logic [7:0] cam_wr_addr, cam_wr_data;
    logic [4:0] count;
    logic       full, empty;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int rsp_cnt = 0;

    cam_ctrl #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .EMPTY_KEY(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_addr(rsp_addr),
        .cam_srch_data(cam_srch_data), .cam_found(cam_found), .cam_srch_addr(cam_srch_addr),
        .cam_wr_en(cam_wr_en), .cam_wr_addr(cam_wr_addr), .cam_wr_data(cam_wr_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Behavioural CAM: reset to zero, write on rising edge, combinational search.
    logic [7:0] cam_mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) cam_mem[i] <= 8'h00;
        end else if (cam_wr_en) begin
            cam_mem[cam_wr_addr[3:0]] <= cam_wr_data;
        end
    end
    always_comb begin
        cam_found     = 1'b0;
        cam_srch_addr = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (cam_mem[i] == cam_srch_data) begin
                cam_found     = 1'b1;
                cam_srch_addr = 4'(i);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cam_wr_en) wr_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    // Reference model: a table of slots, each either free or holding one key.
    logic [7:0] m_key [16];
    bit         m_occ [16];

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_occ[i] = 1'b0;
            m_key[i] = 8'h00;
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += m_occ[i] ? 1 : 0;
        return n;
    endfunction

    task automatic model_exec(input bit op, input logic [7:0] key,
                              output logic [1:0] st, output logic [3:0] addr);
        int hit = -1;
        int fr = -1;
        st = 2'b11;
        addr = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (m_occ[i] && m_key[i] == key && hit < 0) hit = i;
            if (!m_occ[i] && fr < 0) fr = i;
        end
        if (key == 8'h00) begin
            st = 2'b11;
        end else if (!op) begin
            if (hit >= 0) begin
                st = 2'b01; addr = 4'(hit);
            end else if (fr < 0) begin
                st = 2'b10;
            end else begin
                st = 2'b00; addr = 4'(fr); m_occ[fr] = 1'b1; m_key[fr] = key;
            end
        end else if (hit >= 0) begin
            st = 2'b00; addr = 4'(hit); m_occ[hit] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // Drives one request through the handshake and collects what came back.
    task automatic do_req(input bit op, input logic [7:0] key,
                          output logic [1:0] st, output logic [3:0] addr,
                          output int lat, output int wrd, output bit tmo);
        int n = 0;
        int w0;
        tmo = 1'b0; st = 2'b00; addr = 4'd0; lat = 0; wrd = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_key = key;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) tmo = 1'b1;
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) tmo = 1'b1;
        st = rsp_status;
        addr = rsp_addr;
        wrd = wr_cnt - w0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || cam_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b rsp_valid=%b wr_en=%b exp 0 0 0", req_ready, rsp_valid, cam_wr_en);
        end
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rsp_status !== 2'b00 || rsp_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got count=%0d empty=%b full=%b st=%b addr=%0d exp 0 1 0 00 0",
                     count, empty, full, rsp_status, rsp_addr);
        end
        checks++;
        if (cam_wr_addr !== 8'h00 || cam_wr_data !== 8'h00 || cam_srch_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_cam got wr_addr=%h wr_data=%h srch=%h exp 00 00 00", cam_wr_addr, cam_wr_data, cam_srch_data);
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 1", req_ready);
        end
    endtask

    // Shared response check pattern repeated inline per scenario.
    task automatic test_basic();
        bit ops [3] = '{1'b0, 1'b0, 1'b0};
        logic [7:0] keys [3] = '{8'h5A, 8'h3C, 8'h5A};
        logic [1:0] st, est; logic [3:0] ad, ead; int lat, wrd; bit tmo;
        for (int k = 0; k < 3; k++) begin
            do_req(ops[k], keys[k], st, ad, lat, wrd, tmo);
            model_exec(ops[k], keys[k], est, ead);
            checks++;
            if (tmo || st !== est || ad !== ead) begin
                errors++;
                $display("FAIL basic_rsp[%0d] got st=%b addr=%0d tmo=%0d exp st=%b addr=%0d", k, st, ad, tmo, est, ead);
            end
            checks++;
            if (lat !== 3 || wrd !== ((est == 2'b00) ? 1 : 0)) begin
                errors++;
                $display("FAIL basic_lat_wr[%0d] got lat=%0d wr=%0d exp lat=3 wr=%0d", k, lat, wrd, (est == 2'b00) ? 1 : 0);
            end
            checks++;
            if (count !== 5'(m_count()) || empty !== (m_count() == 0) || full !== (m_count() == 16)) begin
                errors++;
                $display("FAIL basic_count[%0d] got count=%0d empty=%b full=%b exp count=%0d", k, count, empty, full, m_count());
            end
        end
    endtask

    task automatic test_fill();
        logic [1:0] st, est; logic [3:0] ad, ead; int lat, wrd; bit tmo;
        logic [7:0] key;
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            key = (k < 16) ? 8'(k + 1) : 8'h77;
            do_req(1'b0, key, st, ad, lat, wrd, tmo);
            model_exec(1'b0, key, est, ead);
            checks++;
            if (tmo || st !== est || ad !== ead || lat !== 3 || wrd !== ((est == 2'b00) ? 1 : 0)) begin
                errors++;
                $display("FAIL fill_rsp[%0d] got st=%b addr=%0d lat=%0d wr=%0d exp st=%b addr=%0d lat=3", k, st, ad, lat, wrd, est, ead);
            end
        end
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got count=%0d full=%b empty=%b exp 16 1 0", count, full, empty);
        end
    endtask

    task automatic test_delete_miss();
        bit ops [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] keys [5] = '{8'h04, 8'h77, 8'h99, 8'h00, 8'h00};
        logic [1:0] st, est; logic [3:0] ad, ead; int lat, wrd; bit tmo;
        for (int k = 0; k < 5; k++) begin
            do_req(ops[k], keys[k], st, ad, lat, wrd, tmo);
            model_exec(ops[k], keys[k], est, ead);
            checks++;
            if (tmo || st !== est || ad !== ead || lat !== 3 || wrd !== ((est == 2'b00) ? 1 : 0)) begin
                errors++;
                $display("FAIL delmiss_rsp[%0d] got st=%b addr=%0d lat=%0d wr=%0d exp st=%b addr=%0d", k, st, ad, lat, wrd, est, ead);
            end
            checks++;
            if (count !== 5'(m_count()) || full !== (m_count() == 16)) begin
                errors++;
                $display("FAIL delmiss_count[%0d] got count=%0d full=%b exp %0d", k, count, full, m_count());
            end
            if (k == 0) begin
                checks++;
                if (cam_mem[3] !== 8'h00) begin
                    errors++;
                    $display("FAIL delmiss_cam3 got %h exp 00", cam_mem[3]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] st, est; logic [3:0] ad, ead; int lat, wrd; bit tmo;
        bit op; logic [7:0] key;
        apply_reset();
        for (int k = 0; k < 80; k++) begin
            op = ($urandom_range(0, 3) == 0);
            key = 8'($urandom_range(0, 20));
            do_req(op, key, st, ad, lat, wrd, tmo);
            model_exec(op, key, est, ead);
            checks++;
            if (tmo || st !== est || ad !== ead || lat !== 3 || wrd !== ((est == 2'b00) ? 1 : 0)) begin
                errors++;
                $display("FAIL rand_rsp[%0d] op=%0d key=%h got st=%b addr=%0d lat=%0d wr=%0d exp st=%b addr=%0d",
                         k, op, key, st, ad, lat, wrd, est, ead);
            end
            checks++;
            if (count !== 5'(m_count()) || empty !== (m_count() == 0) || full !== (m_count() == 16)) begin
                errors++;
                $display("FAIL rand_count[%0d] got count=%0d empty=%b full=%b exp %0d", k, count, empty, full, m_count());
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ops [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] keys [4] = '{8'h5A, 8'h5A, 8'h21, 8'h22};
        int hs [4]; int rc [4];
        logic [1:0] est [4]; logic [3:0] ead [4];
        logic [1:0] gst [4]; logic [3:0] gad [4];
        int k = 0; int nr = 0; bit upd = 1'b0;
        apply_reset();
        @(negedge clk);
        req_valid = 1'b1; req_op = ops[0]; req_key = keys[0];
        for (int c = 0; c < 60 && nr < 4; c++) begin
            if (req_valid && req_ready && k < 4) begin
                hs[k] = cyc;
                model_exec(ops[k], keys[k], est[k], ead[k]);
                k++;
                upd = 1'b1;
            end
            if (rsp_valid && nr < 4) begin
                rc[nr] = cyc; gst[nr] = rsp_status; gad[nr] = rsp_addr;
                nr++;
            end
            @(negedge clk);
            if (upd) begin
                upd = 1'b0;
                if (k < 4) begin
                    req_op = ops[k]; req_key = keys[k];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        checks++;
        if (nr !== 4 || k !== 4) begin
            errors++;
            $display("FAIL b2b_count got handshakes=%0d responses=%0d exp 4 4", k, nr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gst[i] !== est[i] || gad[i] !== ead[i] || rc[i] - hs[i] !== 3 || (i > 0 && hs[i] - hs[i-1] !== 4)) begin
                    errors++;
                    $display("FAIL b2b[%0d] got st=%b addr=%0d lat=%0d gap=%0d exp st=%b addr=%0d lat=3 gap=4",
                             i, gst[i], gad[i], rc[i] - hs[i], (i > 0) ? hs[i] - hs[i-1] : 4, est[i], ead[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [1:0] st, est; logic [3:0] ad, ead; int lat, wrd; bit tmo;
        int w0, r0, n;
        apply_reset();
        do_req(1'b0, 8'h11, st, ad, lat, wrd, tmo);
        model_exec(1'b0, 8'h11, est, ead);
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_key = 8'h5A;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        w0 = wr_cnt; r0 = rsp_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (6) @(negedge clk);
        checks++;
        if (wr_cnt !== w0 || rsp_cnt !== r0) begin
            errors++;
            $display("FAIL midrst_pulses got wr=%0d rsp=%0d exp 0 0", wr_cnt - w0, rsp_cnt - r0);
        end
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got count=%0d empty=%b full=%b exp 0 1 0", count, empty, full);
        end
        do_req(1'b0, 8'h5A, st, ad, lat, wrd, tmo);
        model_exec(1'b0, 8'h5A, est, ead);
        checks++;
        if (tmo || st !== est || ad !== ead || lat !== 3 || wrd !== 1 || count !== 5'd1) begin
            errors++;
            $display("FAIL midrst_next got st=%b addr=%0d lat=%0d wr=%0d count=%0d exp st=%b addr=%0d lat=3 wr=1 count=1",
                     st, ad, lat, wrd, count, est, ead);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 1'b0;
        req_key = 8'h00;
        model_clear();
        test_reset();
        test_basic();
        test_fill();
        test_delete_miss();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired before completion");
        $fatal(1);
    end
endmodule
